// File: rtl/maquina_maluca_multi.sv
// rtl/maquina_maluca_multi.sv - multi-cup coffee machine FSM with reservoir tracking
//
// Brews `cups` cups per run, refilling the reservoir only when it reads empty.
// Stage durations are parameters; `state` keeps the legacy 4-bit codes.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        begin a run (sampled only in IDLE, ignored when cups == 0)
//   cups         number of cups to brew, latched with start
//   abort        return to IDLE from any busy state without completing
//   state        current state code (1..9)
//   busy         high whenever state != IDLE
//   cups_done    cups completed in the current or last run
//   water_level  cups of water left in the reservoir
//   done         one-cycle pulse on the first IDLE cycle after a normal completion
module maquina_maluca_multi #(
  parameter int CUPS_W          = 4,
  parameter int LEVEL_W         = 4,
  parameter int WATER_CAP       = 1,
  parameter int ENCHER_CYCLES   = 1,
  parameter int MOER_CYCLES     = 1,
  parameter int EXTRACAO_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CUPS_W-1:0] cups,
  input  logic              abort,
  output logic [3:0]        state,
  output logic              busy,
  output logic [CUPS_W-1:0] cups_done,
  output logic [LEVEL_W-1:0] water_level,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE                = 4'd1,
    LIGAR_MAQUINA       = 4'd2,
    VERIFICAR_AGUA      = 4'd3,
    ENCHER_RESERVATORIO = 4'd4,
    MOER_CAFE           = 4'd5,
    COLOCAR_NO_FILTRO   = 4'd6,
    PASSAR_AGITADOR     = 4'd7,
    TAMPEAR             = 4'd8,
    REALIZAR_EXTRACAO   = 4'd9
  } state_t;

  localparam int MAX_EM  = (ENCHER_CYCLES > MOER_CYCLES) ? ENCHER_CYCLES : MOER_CYCLES;
  localparam int MAX_CYC = (MAX_EM > EXTRACAO_CYCLES) ? MAX_EM : EXTRACAO_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Timer counts cycles already spent in the current state; a stage exits on its last count.
  localparam logic [TMR_W-1:0] ENCHER_LAST   = TMR_W'(ENCHER_CYCLES - 1);
  localparam logic [TMR_W-1:0] MOER_LAST     = TMR_W'(MOER_CYCLES - 1);
  localparam logic [TMR_W-1:0] EXTRACAO_LAST = TMR_W'(EXTRACAO_CYCLES - 1);

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [CUPS_W-1:0]   target_q, target_d;
  logic [CUPS_W-1:0]   cups_done_q, cups_done_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic                done_q, done_d;
  logic                stage_last;

  always_comb begin
    stage_last = 1'b1;
    case (state_q)
      ENCHER_RESERVATORIO: stage_last = (timer_q == ENCHER_LAST);
      MOER_CAFE:           stage_last = (timer_q == MOER_LAST);
      REALIZAR_EXTRACAO:   stage_last = (timer_q == EXTRACAO_LAST);
      default:             stage_last = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    target_d    = target_q;
    cups_done_d = cups_done_q;
    level_d     = level_q;
    done_d      = 1'b0;

    // Abort drops the run in place: an unfinished refill or extraction leaves no trace.
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && cups != '0) begin
            target_d    = cups;
            cups_done_d = '0;
            state_d     = LIGAR_MAQUINA;
          end
        end
        LIGAR_MAQUINA:  state_d = VERIFICAR_AGUA;
        VERIFICAR_AGUA: state_d = (level_q == '0) ? ENCHER_RESERVATORIO : MOER_CAFE;
        ENCHER_RESERVATORIO: begin
          if (stage_last) begin
            level_d = LEVEL_W'(WATER_CAP);
            state_d = VERIFICAR_AGUA;
          end
        end
        MOER_CAFE: begin
          if (stage_last) state_d = COLOCAR_NO_FILTRO;
        end
        COLOCAR_NO_FILTRO: state_d = PASSAR_AGITADOR;
        PASSAR_AGITADOR:   state_d = TAMPEAR;
        TAMPEAR:           state_d = REALIZAR_EXTRACAO;
        REALIZAR_EXTRACAO: begin
          if (stage_last) begin
            level_d     = level_q - 1'b1;
            cups_done_d = cups_done_q + 1'b1;
            if (cups_done_d == target_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = VERIFICAR_AGUA;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      // Reload on every entry (including re-entry of VERIFICAR_AGUA after a refill).
      if (state_d == state_q && state_q != IDLE) begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      target_q    <= '0;
      cups_done_q <= '0;
      level_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      target_q    <= target_d;
      cups_done_q <= cups_done_d;
      level_q     <= level_d;
      done_q      <= done_d;
    end
  end

  assign state       = state_q;
  assign busy        = (state_q != IDLE);
  assign cups_done   = cups_done_q;
  assign water_level = level_q;
  assign done        = done_q;

endmodule

// File: tb/tb_maquina_maluca_multi.sv
// tb/tb_maquina_maluca_multi.sv - self-checking bench for maquina_maluca_multi
module tb_maquina_maluca_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] cups = 4'd0;
  logic       abort = 1'b0;

  logic [3:0] d_st   [2];
  logic       d_busy [2];
  logic [3:0] d_cd   [2];
  logic [3:0] d_lvl  [2];
  logic       d_dn   [2];

  always #5 clk = ~clk;

  maquina_maluca_multi u0 (
    .clk(clk), .rst(rst), .start(start), .cups(cups), .abort(abort),
    .state(d_st[0]), .busy(d_busy[0]), .cups_done(d_cd[0]),
    .water_level(d_lvl[0]), .done(d_dn[0])
  );

  maquina_maluca_multi #(
    .WATER_CAP(3), .ENCHER_CYCLES(2), .MOER_CYCLES(3), .EXTRACAO_CYCLES(4)
  ) u1 (
    .clk(clk), .rst(rst), .start(start), .cups(cups), .abort(abort),
    .state(d_st[1]), .busy(d_busy[1]), .cups_done(d_cd[1]),
    .water_level(d_lvl[1]), .done(d_dn[1])
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Behavioural model: a run is expanded into its full per-cycle trace when it starts.
  typedef struct {
    int st;
    int lvl;
    int cd;
    bit dn;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  int   cap [2] = '{1, 3};
  int   ench[2] = '{1, 2};
  int   moer[2] = '{1, 3};
  int   extr[2] = '{1, 4};
  int   cur_st [2] = '{1, 1};
  int   cur_lvl[2] = '{0, 0};
  int   cur_cd [2] = '{0, 0};
  bit   cur_dn [2] = '{0, 0};

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int i, input int st, input int lvl, input int cd, input bit dn);
    rec_t r;
    r.st = st; r.lvl = lvl; r.cd = cd; r.dn = dn;
    if (i == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  task automatic build(input int i, input int n);
    int lvl;
    int cd;
    lvl = cur_lvl[i];
    cd = 0;
    push(i, 2, lvl, cd, 0);
    for (int c = 0; c < n; c++) begin
      push(i, 3, lvl, cd, 0);
      if (lvl == 0) begin
        for (int k = 0; k < ench[i]; k++) push(i, 4, lvl, cd, 0);
        lvl = cap[i];
        push(i, 3, lvl, cd, 0);
      end
      for (int k = 0; k < moer[i]; k++) push(i, 5, lvl, cd, 0);
      push(i, 6, lvl, cd, 0);
      push(i, 7, lvl, cd, 0);
      push(i, 8, lvl, cd, 0);
      for (int k = 0; k < extr[i]; k++) push(i, 9, lvl, cd, 0);
      lvl = lvl - 1;
      cd = cd + 1;
    end
    push(i, 1, lvl, cd, 1);
  endtask

  task automatic model_step(input int i);
    rec_t r;
    if (rst) begin
      if (i == 0) q0.delete(); else q1.delete();
      cur_st[i] = 1; cur_lvl[i] = 0; cur_cd[i] = 0; cur_dn[i] = 0;
    end else if (cur_st[i] != 1 && abort) begin
      if (i == 0) q0.delete(); else q1.delete();
      cur_st[i] = 1; cur_dn[i] = 0;
    end else begin
      if (qsize(i) == 0) begin
        cur_dn[i] = 0;
        if (start && cups != 4'd0) build(i, int'(cups));
      end
      if (qsize(i) != 0) begin
        r = (i == 0) ? q0.pop_front() : q1.pop_front();
        cur_st[i] = r.st; cur_lvl[i] = r.lvl; cur_cd[i] = r.cd; cur_dn[i] = r.dn;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (d_st[i] !== 4'(cur_st[i]) || d_busy[i] !== (cur_st[i] != 1) ||
            d_cd[i] !== 4'(cur_cd[i]) || d_lvl[i] !== 4'(cur_lvl[i]) || d_dn[i] !== cur_dn[i]) begin
          n_err++;
          $display("FAIL model_u%0d t=%0t: got st=%0d busy=%0d cd=%0d lvl=%0d done=%0d, want st=%0d busy=%0d cd=%0d lvl=%0d done=%0d",
                   i, $time, d_st[i], d_busy[i], d_cd[i], d_lvl[i], d_dn[i],
                   cur_st[i], (cur_st[i] != 1), cur_cd[i], cur_lvl[i], cur_dn[i]);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_st(input int i, input int s, input int budget);
    int k;
    k = 0;
    while (d_st[i] !== 4'(s) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (d_st[i] !== 4'(s)) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_u%0d_state: state=%0d, want %0d within %0d cycles", i, d_st[i], s, budget);
    end
  endtask

  int tr0[17];
  int dn0[17];
  int tr1[17];
  int exp1[10] = '{2, 3, 4, 3, 5, 6, 7, 8, 9, 1};
  int exp4[8]  = '{2, 3, 5, 6, 7, 8, 9, 1};
  int comp[$];

  initial begin
    int n4, n5, n9, nb, last;
    bit pulsed;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_state", int'(d_st[0]), 1);
    chk("reset_level", int'(d_lvl[1]), 0);
    chk("reset_busy", int'(d_busy[0]), 0);

    // Single-cup run on both instances: legacy trace and stretched stage timing.
    start = 1'b1; cups = 4'd1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 0) chk("model_u1_queue_len", qsize(1), 15);
      tr0[k] = int'(d_st[0]);
      dn0[k] = int'(d_dn[0]);
      tr1[k] = int'(d_st[1]);
    end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t1_trace_%0d", k), tr0[k], exp1[k]);
      chk($sformatf("t1_done_%0d", k), dn0[k], (k == 9) ? 1 : 0);
    end
    chk("t1_cups_done", int'(d_cd[0]), 1);
    chk("t1_level", int'(d_lvl[0]), 0);
    chk("t1_busy_end", int'(d_busy[0]), 0);
    n4 = 0; n5 = 0; n9 = 0; nb = 0;
    for (int k = 0; k < 16; k++) begin
      if (tr1[k] == 4) n4++;
      if (tr1[k] == 5) n5++;
      if (tr1[k] == 9) n9++;
      if (tr1[k] != 1) nb++;
    end
    chk("t3_encher_cycles", n4, 2);
    chk("t3_moer_cycles", n5, 3);
    chk("t3_extracao_cycles", n9, 4);
    chk("t3_busy_cycles", nb, 15);
    chk("t3_idle_at_16", tr1[15], 1);
    chk("t3_level_end", int'(d_lvl[1]), 2);

    // Abort during u1's first MOER_CAFE (u0 is mid-refill at that moment).
    start = 1'b1; cups = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_st(1, 5, 20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_abort_state", int'(d_st[1]), 1);
    chk("t4_abort_done", int'(d_dn[1]), 0);
    chk("t4_abort_cups_done", int'(d_cd[1]), 0);
    chk("t4_abort_level", int'(d_lvl[1]), 2);
    chk("t4_abort_refill_u0_level", int'(d_lvl[0]), 0);

    // Rerun with water available: no refill; a start pulse mid-run is ignored.
    start = 1'b1; cups = 4'd1;
    @(negedge clk);
    start = 1'b0;
    last = 0;
    pulsed = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (int'(d_st[1]) != last) begin
        comp.push_back(int'(d_st[1]));
        last = int'(d_st[1]);
      end
      if (d_st[1] == 4'd5 && !pulsed) begin
        start = 1'b1; cups = 4'd5; pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (d_st[1] == 4'd1) break;
      @(negedge clk);
    end
    start = 1'b0;
    chk("t4_rerun_len", comp.size(), 8);
    if (comp.size() == 8) begin
      for (int k = 0; k < 8; k++) chk($sformatf("t4_rerun_%0d", k), comp[k], exp4[k]);
    end
    chk("t4_rerun_level", int'(d_lvl[1]), 1);
    chk("t4_rerun_cups_done", int'(d_cd[1]), 1);
    wait_st(0, 1, 100);

    // cups == 0 is ignored.
    start = 1'b1; cups = 4'd0;
    @(negedge clk);
    start = 1'b0;
    chk("t5_zero_cups_u0", int'(d_st[0]), 1);
    chk("t5_zero_cups_u1", int'(d_st[1]), 1);

    // Reset while u0 is extracting.
    start = 1'b1; cups = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_st(0, 9, 30);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_state", int'(d_st[0]), 1);
    chk("t5_rst_level", int'(d_lvl[0]), 0);
    chk("t5_rst_cups_done", int'(d_cd[0]), 0);
    chk("t5_rst_done", int'(d_dn[0]), 0);
    chk("t5_rst_u1_level", int'(d_lvl[1]), 0);

    // Random traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 3) == 0);
      cups  = 4'($urandom_range(0, 5));
      abort = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/maquina_maluca_multi.md
Name: maquina_maluca_multi

Overview:
Parametrised successor of the single-shot coffee-machine FSM. It brews a requested number of cups in one run. Stage durations are configurable. It tracks reservoir water level across runs and refills only when empty. It supports abort. The 4-bit state encoding is unchanged, so existing monitors and benches still decode `state`.

Parameters:
CUPS_W, 4, width of the cup-count request and of `cups_done`.
LEVEL_W, 4, width of `water_level`.
WATER_CAP, 1, cups of water per refill; legal range 1..2^LEVEL_W-1.
ENCHER_CYCLES, 1, cycles spent in ENCHER_RESERVATORIO; must be ≥1.
MOER_CYCLES, 1, cycles spent in MOER_CAFE; must be ≥1.
EXTRACAO_CYCLES, 1, cycles spent in REALIZAR_EXTRACAO; must be ≥1.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset.
start  in  1  begin a run; sampled only in IDLE.
cups  in  CUPS_W  number of cups to brew; latched with start.
abort  in  1  terminate the run; returns to IDLE.
state  out  4  current state code.
busy  out  1  high whenever state != IDLE (combinational from state).
cups_done  out  CUPS_W  cups completed in the current or last run.
water_level  out  LEVEL_W  cups of water left in the reservoir.
done  out  1  one-cycle pulse when a run completes normally.

Behaviour:
- One clock `clk`; reset `rst` is synchronous and active-high.
- Reset (takes effect at the next edge; overrides everything, including mid-run):
  - state=IDLE(1), water_level=0, cups_done=0, done=0.
  - Internal stage timer and latched target are cleared.
- State codes:
  - IDLE=1, LIGAR_MAQUINA=2, VERIFICAR_AGUA=3, ENCHER_RESERVATORIO=4, MOER_CAFE=5.
  - COLOCAR_NO_FILTRO=6, PASSAR_AGITADOR=7, TAMPEAR=8, REALIZAR_EXTRACAO=9.
  - No other codes ever appear.
- IDLE:
  - start=1 and cups!=0: latch target=cups, clear cups_done, go to LIGAR_MAQUINA.
  - start with cups==0: ignored.
  - start outside IDLE: ignored. `cups` changes after the latch are ignored.
- LIGAR_MAQUINA: 1 cycle, then VERIFICAR_AGUA.
- VERIFICAR_AGUA: 1 cycle. Goes to ENCHER_RESERVATORIO if water_level==0, else to MOER_CAFE.
- ENCHER_RESERVATORIO:
  - Occupies exactly ENCHER_CYCLES cycles.
  - On exit, water_level ← WATER_CAP; next state is VERIFICAR_AGUA.
- MOER_CAFE: exactly MOER_CYCLES cycles, then COLOCAR_NO_FILTRO.
- COLOCAR_NO_FILTRO, PASSAR_AGITADOR, TAMPEAR: 1 cycle each, in that order, then REALIZAR_EXTRACAO.
- REALIZAR_EXTRACAO: exactly EXTRACAO_CYCLES cycles. On exit:
  - water_level decrements by 1.
  - cups_done increments by 1.
  - If the new cups_done == target: go to IDLE and assert done for the single cycle in which state first reads IDLE.
  - Otherwise: go to VERIFICAR_AGUA.
- Stage timer: a state with duration N is visible on `state` for exactly N consecutive sampled cycles. The timer reloads on every state entry.
- abort:
  - Priority below rst, above all transitions. Effective in any non-IDLE state.
  - Next state is IDLE; done stays 0.
  - cups_done holds its value; water_level is unchanged (an interrupted refill does not fill; an interrupted extraction does not consume).
  - abort in IDLE is a no-op.
  - start and abort together in IDLE: start wins (abort is inert in IDLE).
- water_level persists across runs and is not cleared on normal completion or abort.
- Arithmetic: the decrement never occurs at 0, because VERIFICAR_AGUA guarantees ≥1 before MOER_CAFE. cups_done never exceeds target.
- Default parameters reproduce the legacy single-cup trace exactly.

Test Plan:
1. Defaults. Reset 2 cycles, then start=1 with cups=1 for one cycle.
   - state after successive edges: 2,3,4,3,5,6,7,8,9,1.
   - done=1 only on the cycle state=1; cups_done=1; water_level=0; busy=0 at the end.
2. WATER_CAP=2, cups=3.
   - ENCHER_RESERVATORIO visited twice: before cup 1 and before cup 3.
   - water_level sequence after each extraction: 1, 0, 1.
   - Ends with cups_done=3, done pulse once, water_level=1.
3. ENCHER_CYCLES=2, MOER_CYCLES=3, EXTRACAO_CYCLES=4, cups=1.
   - state 4 held 2 cycles, 5 held 3 cycles, 9 held 4 cycles.
   - Start to IDLE takes 15 cycles. A second run starts with water_level=0 and therefore refills again.
4. Defaults, WATER_CAP=3, cups=2.
   - Assert abort during the first MOER_CAFE: state=1 next cycle, done=0, cups_done=0, water_level=3.
   - A new start with cups=1 then skips ENCHER: trace 2,3,5,6,7,8,9,1; water_level ends at 2.
5. Edge cases:
   - start with cups=0: state stays 1.
   - start pulsed while state=5: no effect on the trace.
   - rst asserted while state=9: next edge gives state=1, water_level=0, cups_done=0, done=0.
